reg_read_seq: RTL and testbench

REG_READ_SEQ -- requirements
Module: reg_read_seq

---
 rtl/reg_read_seq_pkg.sv | 25 ++
 rtl/rrs_addr_dec.sv | 30 +++
 rtl/reg_read_seq.sv | 169 ++++++++++++++++
 tb/tb_reg_read_seq.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_read_seq_pkg.sv
// reg_read_seq_pkg
// Shared definitions for the register read sequencer:
//   - default NREGS / WIDTH / ADDR_W values used by reg_read_seq
//   - state encoding of the read sequence FSM
package reg_read_seq_pkg;

  localparam int RRS_NREGS_DEFAULT  = 8;
  localparam int RRS_WIDTH_DEFAULT  = 8;
  localparam int RRS_ADDR_W_DEFAULT = 3;

  // Read sequence states. INIT clears every cell latch once after reset,
  // ADDR..CLR walk one cell through select / read / latch / sample.
  typedef enum logic [3:0] {
    INIT   = 4'd0,
    IDLE   = 4'd1,
    ADDR   = 4'd2,
    RDEN   = 4'd3,
    LATCH  = 4'd4,
    DROPRD = 4'd5,
    SAMPLE = 4'd6,
    CLR    = 4'd7,
    RESP   = 4'd8
  } rrs_state_e;

endpackage

// File: rtl/rrs_addr_dec.sv
// rrs_addr_dec
// Address to one-hot cell select decoder with out-of-range detect.
// Ports:
//   addr [ADDR_W-1:0] : register index
//   sel  [NREGS-1:0]  : one-hot select, all zero when addr is out of range
//   err               : addr >= NREGS
module rrs_addr_dec #(
  parameter int NREGS  = 8,
  parameter int ADDR_W = 3
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [NREGS-1:0]  sel,
  output logic              err
);

  // Match against each valid index; no match means the address is outside
  // the populated cell range. Done per index so no compare against NREGS is
  // needed when NREGS fills the whole address space.
  always_comb begin
    sel = '0;
    err = 1'b1;
    for (int i = 0; i < NREGS; i++) begin
      if (addr == ADDR_W'(i)) begin
        sel[i] = 1'b1;
        err    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/reg_read_seq.sv
// reg_read_seq
// Sequences a single read of one register cell on a shared tristate
// visibility bus: select the cell, pulse its read enable, latch, drop the
// read, sample the bus, clear the latch, then present the response.
//
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   req_valid/req_ready: read request handshake, req_addr = cell index
//   rsp_valid/rsp_ready: response handshake, rsp_data / rsp_err payload
//   rsp_par            : XOR of rsp_data (only when RRS_PARITY_EN is defined)
//   sel                : one-hot cell select (all ones during INIT)
//   rd, rd_latch       : cell read enable / read-latch enable
//   bus_in             : shared visibility bus
//
// Configuration macro: RRS_PARITY_EN adds the rsp_par output.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. valid, once raised, holds its payload stable until that
// edge; ready never depends combinationally on valid.
//
// Timing: all outputs are registered from the current state, so what is
// visible on the pins during a cycle is the output set of the state held in
// the previous cycle. The FSM state therefore runs one cycle ahead of the
// pins: reset shows all zeros while state is INIT, the next edge shows the
// INIT outputs, and rsp_valid appears seven edges after the accepting edge.
module reg_read_seq
  import reg_read_seq_pkg::*;
#(
  parameter int NREGS  = RRS_NREGS_DEFAULT,
  parameter int WIDTH  = RRS_WIDTH_DEFAULT,
  parameter int ADDR_W = RRS_ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_data,
  output logic              rsp_err,
`ifdef RRS_PARITY_EN
  output logic              rsp_par,
`endif
  output logic [NREGS-1:0]  sel,
  output logic              rd,
  output logic              rd_latch,
  input  logic [WIDTH-1:0]  bus_in
);

  rrs_state_e        state;
  logic [ADDR_W-1:0] addr_q;
  logic [NREGS-1:0]  dec_sel;
  logic              dec_err;
  logic              accept;
  logic              rsp_fire;

  rrs_addr_dec #(
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W)
  ) u_addr_dec (
    .addr (addr_q),
    .sel  (dec_sel),
    .err  (dec_err)
  );

  assign accept   = (state == IDLE) && req_ready && req_valid;
  assign rsp_fire = rsp_valid && rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT;
      addr_q    <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
`ifdef RRS_PARITY_EN
      rsp_par   <= 1'b0;
`endif
      sel       <= '0;
      rd        <= 1'b0;
      rd_latch  <= 1'b0;
    end else begin
      // Strobes default low; each state raises what it owns.
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      sel       <= '0;
      rd        <= 1'b0;
      rd_latch  <= 1'b0;

      case (state)
        INIT: begin
          // Select every cell with the latch enable so all latches clear.
          sel      <= '1;
          rd_latch <= 1'b1;
          state    <= IDLE;
        end

        IDLE: begin
          // Drop ready on the accepting edge so the pins never show a
          // second ready cycle for the same request.
          req_ready <= !accept;
          if (accept) begin
            addr_q <= req_addr;
            state  <= ADDR;
          end
        end

        ADDR: begin
          sel   <= dec_sel;
          state <= RDEN;
        end

        RDEN: begin
          sel   <= dec_sel;
          rd    <= 1'b1;
          state <= LATCH;
        end

        LATCH: begin
          sel      <= dec_sel;
          rd       <= 1'b1;
          rd_latch <= 1'b1;
          state    <= DROPRD;
        end

        DROPRD: begin
          sel      <= dec_sel;
          rd_latch <= 1'b1;
          state    <= SAMPLE;
        end

        SAMPLE: begin
          sel   <= dec_sel;
          state <= CLR;
        end

        CLR: begin
          sel      <= dec_sel;
          rd_latch <= 1'b1;
          // The pins are showing SAMPLE during this cycle, so bus_in now
          // carries the selected cell's value. Out-of-range reads had no
          // cell selected and return zero.
          rsp_data <= dec_err ? '0 : bus_in;
          rsp_err  <= dec_err;
`ifdef RRS_PARITY_EN
          rsp_par  <= dec_err ? 1'b0 : ^bus_in;
`endif
          state    <= RESP;
        end

        RESP: begin
          // rsp_data / rsp_err are only written in CLR, so they hold
          // throughout the response.
          rsp_valid <= !rsp_fire;
          if (rsp_fire) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_read_seq.sv
// tb_reg_read_seq
// Drives two instances in lockstep from the same inputs: the default
// configuration (NREGS=8) and NREGS=6, so addresses 6 and 7 are valid on
// the first and out of range on the second. Define RRS_PARITY_EN to also
// check rsp_par.
module tb_reg_read_seq;

  localparam int W  = 8;
  localparam int EW = W + 2;  // {err, par, data}

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  int   cyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT signals ----------------
  logic         req_valid;
  logic [2:0]   req_addr;
  logic         rsp_ready;
  logic [W-1:0] bus_in;

  logic         req_ready, rsp_valid, rsp_err, rd, rd_latch, par0;
  logic [W-1:0] rsp_data;
  logic [7:0]   sel;

  logic         req_ready6, rsp_valid6, rsp_err6, rd6, rd_latch6, par6;
  logic [W-1:0] rsp_data6;
  logic [5:0]   sel6;

`ifndef RRS_PARITY_EN
  assign par0 = 1'b0;
  assign par6 = 1'b0;
`endif

  reg_read_seq dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
`ifdef RRS_PARITY_EN
    .rsp_par   (par0),
`endif
    .sel       (sel),
    .rd        (rd),
    .rd_latch  (rd_latch),
    .bus_in    (bus_in)
  );

  reg_read_seq #(.NREGS(6)) dut6 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready6),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid6),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data6),
    .rsp_err   (rsp_err6),
`ifdef RRS_PARITY_EN
    .rsp_par   (par6),
`endif
    .sel       (sel6),
    .rd        (rd6),
    .rd_latch  (rd_latch6),
    .bus_in    (bus_in)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp6_q[$];
  int            cyc_q[$];
  int            cyc6_q[$];
  int            acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [EW-1:0] exp_payload(input int nregs, input logic [2:0] a,
                                                input logic [W-1:0] v);
    logic p;
`ifdef RRS_PARITY_EN
    p = ^v;
`else
    p = 1'b0;
`endif
    if (int'(a) < nregs) return {1'b0, p, v};
    return {1'b1, 1'b0, {W{1'b0}}};
  endfunction

  // Monitors: compare the first cycle of each response against the queue
  // head, then require the payload to stay put while rsp_valid is held.
  logic          seen0, seen6;
  logic [EW-1:0] hold0, hold6;

  always @(negedge clk) begin
    if (rst) begin
      seen0 = 1'b0;
    end else if (rsp_valid) begin
      if (!seen0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp: got response data 0x%0h with none expected (cycle %0d)",
                   rsp_data, cyc);
        end else begin
          chk("rsp_payload", 32'({rsp_err, par0, rsp_data}), 32'(exp_q.pop_front()));
          chk("rsp_latency", 32'(cyc), 32'(cyc_q.pop_front()));
        end
        hold0 = {rsp_err, par0, rsp_data};
        seen0 = 1'b1;
      end else begin
        chk("rsp_stable", 32'({rsp_err, par0, rsp_data}), 32'(hold0));
      end
    end else begin
      seen0 = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      seen6 = 1'b0;
    end else if (rsp_valid6) begin
      if (!seen6) begin
        if (exp6_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp6: got response data 0x%0h with none expected (cycle %0d)",
                   rsp_data6, cyc);
        end else begin
          chk("rsp6_payload", 32'({rsp_err6, par6, rsp_data6}), 32'(exp6_q.pop_front()));
          chk("rsp6_latency", 32'(cyc), 32'(cyc6_q.pop_front()));
        end
        hold6 = {rsp_err6, par6, rsp_data6};
        seen6 = 1'b1;
      end else begin
        chk("rsp6_stable", 32'({rsp_err6, par6, rsp_data6}), 32'(hold6));
      end
    end else begin
      seen6 = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk_all_zero(input string tag);
    chk({tag, "_sel"},   32'(sel),  0);
    chk({tag, "_sel6"},  32'(sel6), 0);
    chk({tag, "_ctl"},   32'({rd, rd_latch, rd6, rd_latch6}), 0);
    chk({tag, "_hs"},    32'({req_ready, rsp_valid, req_ready6, rsp_valid6}), 0);
    chk({tag, "_data"},  32'({rsp_err, par0, rsp_data}), 0);
    chk({tag, "_data6"}, 32'({rsp_err6, par6, rsp_data6}), 0);
  endtask

  // Enter with rst high; leaves one cycle into IDLE, aligned #1 after posedge.
  task automatic release_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_all_zero("held_init");
    @(negedge clk);
    chk("init_sel",  32'(sel),  32'h0000_00FF);
    chk("init_sel6", 32'(sel6), 32'h0000_003F);
    chk("init_ctl",  32'({rd, rd_latch, req_ready, rd6, rd_latch6, req_ready6}), 32'b010_010);
    @(negedge clk);
    chk("idle_sel",  32'({sel, sel6}), 0);
    chk("idle_ctl",  32'({rd, rd_latch, req_ready, rd6, rd_latch6, req_ready6}), 32'b001_001);
    @(posedge clk);
    #1;
  endtask

  // Visible output set k cycles after the accepting edge (k = 0..6).
  task automatic chk_phase(input int k, input logic [2:0] a);
    logic [7:0] s8;
    logic [5:0] s6;
    logic       e_rd, e_lat;
    s8    = (k >= 1 && k <= 6) ? (8'd1 << a) : 8'd0;
    s6    = (k >= 1 && k <= 6 && a < 3'd6) ? (6'd1 << a) : 6'd0;
    e_rd  = (k == 2) || (k == 3);
    e_lat = (k == 3) || (k == 4) || (k == 6);
    chk($sformatf("sel_k%0d", k),  32'(sel),  32'(s8));
    chk($sformatf("sel6_k%0d", k), 32'(sel6), 32'(s6));
    chk($sformatf("ctl_k%0d", k),  32'({rd, rd_latch, rd6, rd_latch6}),
        32'({e_rd, e_lat, e_rd, e_lat}));
    chk($sformatf("hs_k%0d", k),   32'({req_ready, rsp_valid, req_ready6, rsp_valid6}), 0);
  endtask

  // Present a request and wait for acceptance; bus_in is kept at ~v so only
  // a capture during the SAMPLE cycle returns v.
  task automatic issue(input logic [2:0] a, input logic [W-1:0] v);
    int n;
    bus_in    = ~v;
    req_addr  = a;
    req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", 32'({req_ready, req_ready6}), 32'b11);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = ~a;
    acc = cyc;
    exp_q.push_back(exp_payload(8, a, v));
    exp6_q.push_back(exp_payload(6, a, v));
    cyc_q.push_back(acc + 7);
    cyc6_q.push_back(acc + 7);
  endtask

  task automatic do_read(input logic [2:0] a, input logic [W-1:0] v, input int stall);
    int n;
    rsp_ready = (stall == 0);
    issue(a, v);
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      chk_phase(k, a);
      @(posedge clk);
      #1;
      if (k == 4) bus_in = v;
      if (k == 5) bus_in = ~v;
    end
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_valid", 32'({rsp_valid, rsp_valid6}), 32'b11);
      chk("stall_ready", 32'({req_ready, req_ready6}), 0);
      chk("stall_sel",   32'({sel, sel6}), 0);
      // A request pulse while busy must be ignored.
      req_valid = (s == 1);
      req_addr  = 3'd2;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while ((rsp_valid || rsp_valid6) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_drain", 32'({rsp_valid, rsp_valid6}), 0);
    @(posedge clk);
    #1;
  endtask

  // Abandon a read with reset while the pins show LATCH.
  task automatic rst_mid(input logic [2:0] a, input logic [W-1:0] v);
    rsp_ready = 1'b1;
    issue(a, v);
    for (int k = 0; k <= 2; k++) begin
      @(negedge clk);
      chk_phase(k, a);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk_phase(3, a);
    #1 rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    exp_q.delete();
    exp6_q.delete();
    cyc_q.delete();
    cyc6_q.delete();
    repeat (3) @(negedge clk);
    chk_all_zero("rst_hold");
    release_reset();
    repeat (4) begin
      @(negedge clk);
      chk("no_rsp_after_rst", 32'({rsp_valid, rsp_valid6}), 0);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = 3'd0;
    rsp_ready = 1'b1;
    bus_in    = '0;
    cyc       = 0;

    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    release_reset();

    do_read(3'd5, 8'hA5, 0);   // in range on both
    do_read(3'd7, 8'h3C, 0);   // out of range on NREGS=6
    do_read(3'd0, 8'h07, 0);   // odd parity
    do_read(3'd3, 8'h03, 4);   // even parity, held response
    do_read(3'd6, 8'h5A, 0);   // first out-of-range index on NREGS=6
    rst_mid(3'd2, 8'hC3);
    do_read(3'd1, 8'hFF, 0);
    do_read(3'd4, 8'h00, 2);

    repeat (3) @(negedge clk);
    chk("exp_q_empty",  32'(exp_q.size()),  0);
    chk("exp6_q_empty", 32'(exp6_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
